dac_sample_feeder: RTL and testbench

- Upstream producer for the 10-bit DAC FIFO stage. It drives that stage's wr/data inputs and watches its low/empty outputs.
- Sample sources: a local programmable sample table (one-shot or loop), a sawtooth ramp, or a triangle wave.
- Refills the DAC FIFO in fixed-size bursts whenever the FIFO reports low, so a CPU is only needed to configure and start it.

---
 rtl/dac_feed_pkg.sv | 22 ++
 rtl/dac_sample_src.sv | 81 ++++++++
 rtl/dac_sample_feeder.sv | 189 ++++++++++++++++++
 tb/tb_dac_sample_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_feed_pkg.sv
// Shared encodings for the DAC sample feeder: FSM states, source modes and
// the DAC sample width.
package dac_feed_pkg;

  localparam int DAC_DW = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_BURST,
    ST_SETTLE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_LOOP    = 2'b01,
    MODE_SAW     = 2'b10,
    MODE_TRI     = 2'b11
  } mode_e;

endpackage

// File: rtl/dac_sample_src.sv
// Sample source for the DAC feeder: programmable table plus index, sawtooth
// and triangle generators. The current sample is valid combinationally.
module dac_sample_src
  import dac_feed_pkg::*;
#(
  parameter int TBL_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we_i,
  input  logic [TBL_AW-1:0] tbl_addr_i,
  input  logic [DAC_DW-1:0] tbl_wdata_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  mode_e             mode_i,
  input  logic [TBL_AW-1:0] tbl_last_i,
  input  logic [DAC_DW-1:0] step_i,
  output logic [DAC_DW-1:0] sample_o,
  output logic              last_o
);

  logic [DAC_DW-1:0] tblMem [2**TBL_AW];
  logic [TBL_AW-1:0] index_q, index_d;
  logic [DAC_DW-1:0] ramp_q, ramp_d;
  logic              up_q, up_d;
  logic [DAC_DW:0]   rampSum;

  // Table contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (tbl_we_i) tblMem[tbl_addr_i] <= tbl_wdata_i;
  end

  assign rampSum  = {1'b0, ramp_q} + {1'b0, step_i};
  assign last_o   = (index_q == tbl_last_i);
  assign sample_o = (mode_i == MODE_ONESHOT || mode_i == MODE_LOOP) ? tblMem[index_q] : ramp_q;

  always_comb begin
    index_d = index_q;
    ramp_d  = ramp_q;
    up_d    = up_q;
    if (clear_i) begin
      index_d = '0;
      ramp_d  = '0;
      up_d    = 1'b1;
    end else if (advance_i) begin
      case (mode_i)
        MODE_ONESHOT, MODE_LOOP: index_d = last_o ? '0 : index_q + TBL_AW'(1);
        MODE_SAW:                ramp_d  = rampSum[DAC_DW-1:0];
        default: begin
          // Triangle clamps at both rails and reverses there.
          if (up_q) begin
            if (rampSum[DAC_DW]) begin
              ramp_d = '1;
              up_d   = 1'b0;
            end else begin
              ramp_d = rampSum[DAC_DW-1:0];
            end
          end else if (ramp_q < step_i) begin
            ramp_d = '0;
            up_d   = 1'b1;
          end else begin
            ramp_d = ramp_q - step_i;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      ramp_q  <= '0;
      up_q    <= 1'b1;
    end else begin
      index_q <= index_d;
      ramp_q  <= ramp_d;
      up_q    <= up_d;
    end
  end

endmodule

// File: rtl/dac_sample_feeder.sv
// Burst refill producer for the 10-bit DAC FIFO: streams table, sawtooth or
// triangle samples into the FIFO whenever it reports low.
module dac_sample_feeder
  import dac_feed_pkg::*;
#(
  parameter int TBL_AW = 6,
  parameter int BL_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we_i,
  input  logic [TBL_AW-1:0] tbl_addr_i,
  input  logic [DAC_DW-1:0] tbl_wdata_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [1:0]        mode_i,
  input  logic [TBL_AW-1:0] tbl_last_i,
  input  logic [DAC_DW-1:0] step_i,
  input  logic [BL_W-1:0]   burst_len_i,
  input  logic              dac_low_i,
  input  logic              dac_empty_i,
  output logic              dac_wr_o,
  output logic [DAC_DW-1:0] dac_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [TBL_AW-1:0] tblLast_q, tblLast_d;
  logic [DAC_DW-1:0] step_q, step_d;
  logic [BL_W-1:0]   burstLen_q, burstLen_d;
  logic [BL_W-1:0]   burstCnt_q, burstCnt_d;
  logic              settle_q, settle_d;
  logic              wr_q, wr_d;
  logic [DAC_DW-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              primed_q, primed_d;
  logic              issueWr, srcClear;
  logic [DAC_DW-1:0] srcSample;
  logic              srcLast;

  dac_sample_src #(.TBL_AW(TBL_AW)) u_src (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_we_i   (tbl_we_i),
    .tbl_addr_i (tbl_addr_i),
    .tbl_wdata_i(tbl_wdata_i),
    .clear_i    (srcClear),
    .advance_i  (issueWr),
    .mode_i     (mode_q),
    .tbl_last_i (tblLast_q),
    .step_i     (step_q),
    .sample_o   (srcSample),
    .last_o     (srcLast)
  );

  // The state leads the registered strobe: the edge issuing the final write of
  // a burst already moves on, so the cycle showing that write is the first
  // SETTLE (or the DONE) cycle.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tblLast_d  = tblLast_q;
    step_d     = step_q;
    burstLen_d = burstLen_q;
    burstCnt_d = burstCnt_q;
    settle_d   = settle_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    primed_d   = primed_q;
    issueWr    = 1'b0;
    srcClear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d    = ST_CHECK;
          mode_d     = mode_e'(mode_i);
          tblLast_d  = tbl_last_i;
          step_d     = step_i;
          burstLen_d = (burst_len_i == '0) ? BL_W'(1) : burst_len_i;
          busy_d     = 1'b1;
          underrun_d = 1'b0;
          primed_d   = 1'b0;
          srcClear   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (dac_low_i) begin
          issueWr    = 1'b1;
          burstCnt_d = BL_W'(1);
        end
      end
      ST_BURST: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          issueWr    = 1'b1;
          burstCnt_d = burstCnt_q + BL_W'(1);
        end
      end
      ST_SETTLE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (settle_q) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = !stop_i;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (issueWr) begin
      wr_d     = 1'b1;
      data_d   = srcSample;
      primed_d = 1'b1;
      if (mode_q == MODE_ONESHOT && srcLast) begin
        state_d = ST_DONE;
      end else if (burstCnt_d == burstLen_q) begin
        state_d  = ST_SETTLE;
        settle_d = 1'b0;
      end else begin
        state_d = ST_BURST;
      end
    end

    if (busy_q && primed_q && dac_empty_i) underrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ONESHOT;
      tblLast_q  <= '0;
      step_q     <= '0;
      burstLen_q <= BL_W'(1);
      burstCnt_q <= '0;
      settle_q   <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tblLast_q  <= tblLast_d;
      step_q     <= step_d;
      burstLen_q <= burstLen_d;
      burstCnt_q <= burstCnt_d;
      settle_q   <= settle_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      primed_q   <= primed_d;
    end
  end

  assign dac_wr_o   = wr_q;
  assign dac_data_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder: a reference model queues expected
// samples, a negedge monitor pops and compares every DAC write.
module tb_dac_sample_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tblWe = 1'b0;
  logic [5:0] tblAddr = '0;
  logic [9:0] tblWdata = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = '0;
  logic [5:0] tblLast = '0;
  logic [9:0] step = '0;
  logic [3:0] burstLen = '0;
  logic       dacLow = 1'b0;
  logic       dacEmpty = 1'b0;
  logic       dacWr;
  logic [9:0] dacData;
  logic       busy;
  logic       done;
  logic       underrun;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int writesSeen = 0;
  int expQ[$];
  int wrCycles[$];
  int shadowTbl[64];
  bit lowRandom = 1'b0;

  dac_sample_feeder #(.TBL_AW(6), .BL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tbl_we_i   (tblWe),
    .tbl_addr_i (tblAddr),
    .tbl_wdata_i(tblWdata),
    .start_i    (start),
    .stop_i     (stop),
    .mode_i     (mode),
    .tbl_last_i (tblLast),
    .step_i     (step),
    .burst_len_i(burstLen),
    .dac_low_i  (dacLow),
    .dac_empty_i(dacEmpty),
    .dac_wr_o   (dacWr),
    .dac_data_o (dacData),
    .busy_o     (busy),
    .done_o     (done),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every write seen must match the head of the expected queue.
  always @(negedge clk) begin
    int expVal;
    if (rst_n && dacWr === 1'b1) begin
      writesSeen++;
      wrCycles.push_back(cycle);
      expVal = (expQ.size() > 0) ? expQ.pop_front() : -1;
      checkOutput("dac_data", 32'(dacData), expVal);
    end
  end

  // Reference model: the sample sequence each source must produce.
  function automatic void expectTable(input int last, input bit loop, input int count);
    for (int k = 0; k < count; k++) expQ.push_back(shadowTbl[loop ? (k % (last + 1)) : k]);
  endfunction

  function automatic void expectSaw(input int stp, input int count);
    for (int k = 0; k < count; k++) expQ.push_back((k * stp) % 1024);
  endfunction

  function automatic void expectTri(input int stp, input int count);
    int v = 0;
    bit up = 1'b1;
    for (int k = 0; k < count; k++) begin
      expQ.push_back(v);
      if (up) begin
        if (v + stp > 1023) begin v = 1023; up = 1'b0; end
        else v = v + stp;
      end else begin
        if (v < stp) begin v = 0; up = 1'b1; end
        else v = v - stp;
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
    if (lowRandom) dacLow = 1'($urandom_range(0, 1));
  endtask

  task automatic writeTable(input int idx, input int val);
    tblWe = 1'b1;
    tblAddr = 6'(idx);
    tblWdata = 10'(val);
    shadowTbl[idx] = val;
    tick();
    tblWe = 1'b0;
  endtask

  // Pulses start with the given configuration, then scrambles the config
  // inputs so any failure to latch them shows up in the data.
  task automatic applyStimulus(input logic [1:0] m, input int last, input int stp, input int bl);
    mode = m;
    tblLast = 6'(last);
    step = 10'(stp);
    burstLen = 4'(bl);
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom);
    tblLast = 6'($urandom);
    step = 10'($urandom);
    burstLen = 4'($urandom);
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n = 0;
    while (writesSeen < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("write budget", (writesSeen >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input int budget, output int dones);
    int n = 0;
    dones = 0;
    do begin
      tick();
      n++;
      if (done) dones++;
    end while (busy && n < budget);
    repeat (3) begin
      tick();
      if (done) dones++;
    end
    checkOutput("busy at end of run", 32'(busy), 32'd0);
  endtask

  task automatic stopRun();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("dac_wr after stop", 32'(dacWr), 32'd0);
    checkOutput("busy after stop", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dones;
    int base;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset dac_wr", 32'(dacWr), 32'd0);
    checkOutput("reset dac_data", 32'(dacData), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] one-shot table, burst 2");
    writeTable(0, 5);
    writeTable(1, 10);
    writeTable(2, 15);
    writeTable(3, 20);
    dacLow = 1'b1;
    wrCycles.delete();
    expectTable(3, 1'b0, 4);
    applyStimulus(2'b00, 3, 0, 2);
    checkOutput("busy after start", 32'(busy), 32'd1);
    waitIdle(200, dones);
    checkOutput("one-shot done pulses", dones, 1);
    checkOutput("one-shot queue drained", expQ.size(), 0);
    checkOutput("one-shot write count", wrCycles.size(), 4);
    if (wrCycles.size() == 4) begin
      checkOutput("one-shot gap 0-1", wrCycles[1] - wrCycles[0], 1);
      checkOutput("one-shot gap 1-2", wrCycles[2] - wrCycles[1], 3);
      checkOutput("one-shot gap 2-3", wrCycles[3] - wrCycles[2], 1);
    end

    $display("[TB] loop table, burst 3, start while busy");
    wrCycles.delete();
    base = writesSeen;
    expectTable(3, 1'b1, 12);
    applyStimulus(2'b01, 3, 0, 3);
    waitWrites(base + 4, 200);
    mode = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitWrites(base + 12, 200);
    stopRun();
    checkOutput("loop queue drained", expQ.size(), 0);
    for (int i = 0; i + 1 < wrCycles.size(); i++)
      checkOutput("loop burst spacing", wrCycles[i + 1] - wrCycles[i], (i % 3 == 2) ? 3 : 1);

    $display("[TB] sawtooth step 300, burst_len 0");
    wrCycles.delete();
    base = writesSeen;
    expectSaw(300, 6);
    applyStimulus(2'b10, 0, 300, 0);
    waitWrites(base + 6, 200);
    stopRun();
    checkOutput("saw queue drained", expQ.size(), 0);
    if (wrCycles.size() >= 2) checkOutput("saw single-write spacing", wrCycles[1] - wrCycles[0], 3);

    $display("[TB] triangle step 400");
    base = writesSeen;
    expectTri(400, 8);
    applyStimulus(2'b11, 0, 400, 4);
    waitWrites(base + 8, 200);
    stopRun();
    checkOutput("tri queue drained", expQ.size(), 0);

    $display("[TB] stop mid-burst and start with stop");
    base = writesSeen;
    expectTable(3, 1'b1, 2);
    applyStimulus(2'b01, 3, 0, 4);
    waitWrites(base + 2, 50);
    stopRun();
    dones = 0;
    repeat (6) begin
      tick();
      if (done) dones++;
    end
    checkOutput("writes after stop", writesSeen - base, 2);
    checkOutput("done after stop", dones, 0);
    base = writesSeen;
    start = 1'b1;
    stop = 1'b1;
    mode = 2'b01;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checkOutput("busy after start+stop", 32'(busy), 32'd0);
    repeat (6) tick();
    checkOutput("writes after start+stop", writesSeen - base, 0);

    $display("[TB] underrun");
    dacLow = 1'b0;
    applyStimulus(2'b01, 3, 0, 1);
    dacEmpty = 1'b1;
    tick();
    dacEmpty = 1'b0;
    tick();
    checkOutput("underrun before first write", 32'(underrun), 32'd0);
    base = writesSeen;
    expectTable(3, 1'b1, 1);
    dacLow = 1'b1;
    waitWrites(base + 1, 50);
    dacLow = 1'b0;
    dacEmpty = 1'b1;
    tick();
    dacEmpty = 1'b0;
    checkOutput("underrun set", 32'(underrun), 32'd1);
    repeat (5) tick();
    checkOutput("underrun holds", 32'(underrun), 32'd1);
    stopRun();
    checkOutput("underrun holds after stop", 32'(underrun), 32'd1);
    applyStimulus(2'b01, 3, 0, 1);
    checkOutput("underrun cleared by start", 32'(underrun), 32'd0);
    stopRun();

    $display("[TB] reset mid-burst");
    dacLow = 1'b1;
    base = writesSeen;
    expectTable(3, 1'b1, 1);
    applyStimulus(2'b01, 3, 0, 4);
    waitWrites(base + 1, 50);
    rst_n = 1'b0;
    #1;
    checkOutput("dac_wr in reset", 32'(dacWr), 32'd0);
    checkOutput("busy in reset", 32'(busy), 32'd0);
    checkOutput("dac_data in reset", 32'(dacData), 32'd0);
    expQ.delete();
    tick();
    rst_n = 1'b1;
    tick();
    base = writesSeen;
    expectTable(1, 1'b0, 2);
    applyStimulus(2'b00, 1, 0, 4);
    waitIdle(200, dones);
    checkOutput("table kept through reset", expQ.size(), 0);
    checkOutput("post-reset done pulses", dones, 1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      int last;
      int m;
      int stp;
      int bl;
      int k;
      last = $urandom_range(0, 15);
      m = $urandom_range(0, 3);
      stp = $urandom_range(0, 1023);
      bl = $urandom_range(0, 15);
      k = $urandom_range(5, 30);
      for (int i = 0; i <= last; i++) writeTable(i, $urandom_range(0, 1023));
      base = writesSeen;
      case (m)
        0: expectTable(last, 1'b0, last + 1);
        1: expectTable(last, 1'b1, k);
        2: expectSaw(stp, k);
        default: expectTri(stp, k);
      endcase
      lowRandom = 1'b1;
      applyStimulus(2'(m), last, stp, bl);
      if (m == 0) begin
        waitIdle(3000, dones);
        checkOutput("random one-shot done pulses", dones, 1);
      end else begin
        waitWrites(base + k, 3000);
        stopRun();
      end
      lowRandom = 1'b0;
      dacLow = 1'b0;
      checkOutput("random queue drained", expQ.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
